// File: rtl/sprite_motion_ctrl.sv
// Frame-locked bouncing-sprite motion controller.
// Origin moves once per FRAME_DIV unpaused frame ticks and reflects off all edges.
module sprite_motion_ctrl #(
  parameter int H_ACTIVE  = 800,
  parameter int V_ACTIVE  = 600,
  parameter int SPR_W     = 200,
  parameter int SPR_H     = 150,
  parameter int INIT_X    = 200,
  parameter int INIT_Y    = 200,
  parameter int FRAME_DIV = 1,
  parameter int PW        = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_tick,
  input  logic          pause,
  input  logic [3:0]    speed,
  output logic [PW-1:0] pos_x,
  output logic [PW-1:0] pos_y,
  output logic          dir_x,
  output logic          dir_y,
  output logic          bounce_x,
  output logic          bounce_y,
  output logic          upd
);

  localparam logic [PW-1:0] MAX_X  = PW'(H_ACTIVE - SPR_W);
  localparam logic [PW-1:0] MAX_Y  = PW'(V_ACTIVE - SPR_H);
  localparam logic [PW-1:0] INI_X  = PW'(INIT_X);
  localparam logic [PW-1:0] INI_Y  = PW'(INIT_Y);
  localparam logic [7:0]    FD_END = 8'(FRAME_DIV - 1);

  logic [7:0]    fdiv;
  logic          fire;
  logic [PW+1:0] nx;
  logic [PW+1:0] ny;

  // Returns {next_pos, next_dir, bounce} for one axis.
  function automatic logic [PW+1:0] step_axis(
    input logic [PW-1:0] pos,
    input logic          dir,
    input logic [3:0]    spd,
    input logic [PW-1:0] lim
  );
    logic [PW:0] sp;
    logic [PW:0] sum;
    logic [PW:0] dif;
    sp  = {{(PW-3){1'b0}}, spd};
    sum = {1'b0, pos} + sp;
    dif = {1'b0, pos} - sp;
    if (spd == 4'd0)
      step_axis = {pos, dir, 1'b0};
    else if (dir) begin
      if (sum >= {1'b0, lim})
        step_axis = {lim, 1'b0, 1'b1};
      else
        step_axis = {sum[PW-1:0], 1'b1, 1'b0};
    end else begin
      if ({1'b0, pos} <= sp)
        step_axis = {{PW{1'b0}}, 1'b1, 1'b1};
      else
        step_axis = {dif[PW-1:0], 1'b0, 1'b0};
    end
  endfunction

  assign fire = frame_tick && !pause && (fdiv == FD_END);
  assign nx   = step_axis(pos_x, dir_x, speed, MAX_X);
  assign ny   = step_axis(pos_y, dir_y, speed, MAX_Y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fdiv     <= 8'd0;
      pos_x    <= INI_X;
      pos_y    <= INI_Y;
      dir_x    <= 1'b1;
      dir_y    <= 1'b1;
      bounce_x <= 1'b0;
      bounce_y <= 1'b0;
      upd      <= 1'b0;
    end else begin
      upd      <= fire;
      bounce_x <= fire && nx[0];
      bounce_y <= fire && ny[0];
      if (frame_tick && !pause)
        fdiv <= fire ? 8'd0 : fdiv + 8'd1;
      if (fire) begin
        pos_x <= nx[PW+1:2];
        dir_x <= nx[1];
        pos_y <= ny[PW+1:2];
        dir_y <= ny[1];
      end
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: four parameterisations vs. a behavioural model.
// Directed scenarios pin the model, then a random run exercises everything.
module tb_sprite_motion_ctrl;
  localparam int N = 4;

  logic       clk = 0;
  logic       rst_n = 0;
  logic       frame_tick = 0;
  logic       pause = 0;
  logic [3:0] speed = 4'd1;

  logic [10:0] px [N];
  logic [10:0] py [N];
  logic        ddx [N];
  logic        ddy [N];
  logic        bx [N];
  logic        by [N];
  logic        up [N];

  int vectors = 0;
  int miscompares = 0;
  int mx [N];
  int my [N];
  int mf [N];
  bit mdx [N];
  bit mdy [N];
  bit mbx [N];
  bit mby [N];
  bit mup [N];
  int upd_cnt [N];
  int bnc_cnt [N];

  always #5 clk = ~clk;

  sprite_motion_ctrl #(.INIT_X(200), .INIT_Y(200), .FRAME_DIV(1)) u0 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .pause(pause),
    .speed(speed), .pos_x(px[0]), .pos_y(py[0]), .dir_x(ddx[0]),
    .dir_y(ddy[0]), .bounce_x(bx[0]), .bounce_y(by[0]), .upd(up[0]));
  sprite_motion_ctrl #(.INIT_X(200), .INIT_Y(440), .FRAME_DIV(3)) u1 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .pause(pause),
    .speed(speed), .pos_x(px[1]), .pos_y(py[1]), .dir_x(ddx[1]),
    .dir_y(ddy[1]), .bounce_x(bx[1]), .bounce_y(by[1]), .upd(up[1]));
  sprite_motion_ctrl #(.INIT_X(599), .INIT_Y(449), .FRAME_DIV(1)) u2 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .pause(pause),
    .speed(speed), .pos_x(px[2]), .pos_y(py[2]), .dir_x(ddx[2]),
    .dir_y(ddy[2]), .bounce_x(bx[2]), .bounce_y(by[2]), .upd(up[2]));
  sprite_motion_ctrl #(.INIT_X(598), .INIT_Y(300), .FRAME_DIV(1)) u3 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .pause(pause),
    .speed(speed), .pos_x(px[3]), .pos_y(py[3]), .dir_x(ddx[3]),
    .dir_y(ddy[3]), .bounce_x(bx[3]), .bounce_y(by[3]), .upd(up[3]));

  function automatic int ix(int k);
    case (k)
      0: return 200;
      1: return 200;
      2: return 599;
      default: return 598;
    endcase
  endfunction

  function automatic int iy(int k);
    case (k)
      0: return 200;
      1: return 440;
      2: return 449;
      default: return 300;
    endcase
  endfunction

  function automatic int fd(int k);
    return (k == 1) ? 3 : 1;
  endfunction

  task automatic chk(string nm, int k, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s[%0d] got %0d expected %0d at %0t",
               nm, k, act, exp, $time);
    end
  endtask

  // Move along a line of length lim; hitting or passing an end clamps and reflects.
  task automatic move(inout int p, inout bit fwd, output bit hit,
                      input int s, input int lim);
    int t;
    hit = 0;
    if (s == 0) return;
    t = fwd ? p + s : p - s;
    if (t >= lim && fwd) begin
      p = lim; fwd = 0; hit = 1;
    end else if (t <= 0 && !fwd) begin
      p = 0; fwd = 1; hit = 1;
    end else
      p = t;
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mx[k] = ix(k); my[k] = iy(k); mf[k] = 0;
      mdx[k] = 1; mdy[k] = 1;
      mbx[k] = 0; mby[k] = 0; mup[k] = 0;
    end
  endtask

  task automatic model_clock();
    for (int k = 0; k < N; k++) begin
      mbx[k] = 0; mby[k] = 0; mup[k] = 0;
      if (frame_tick && !pause) begin
        mf[k] = (mf[k] + 1) % fd(k);
        if (mf[k] == 0) begin
          mup[k] = 1;
          move(mx[k], mdx[k], mbx[k], int'(speed), 600);
          move(my[k], mdy[k], mby[k], int'(speed), 450);
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_clock();
    #1;
    for (int k = 0; k < N; k++) begin
      chk("pos_x", k, int'(px[k]), mx[k]);
      chk("pos_y", k, int'(py[k]), my[k]);
      chk("dir_x", k, int'(ddx[k]), int'(mdx[k]));
      chk("dir_y", k, int'(ddy[k]), int'(mdy[k]));
      chk("bounce_x", k, int'(bx[k]), int'(mbx[k]));
      chk("bounce_y", k, int'(by[k]), int'(mby[k]));
      chk("upd", k, int'(up[k]), int'(mup[k]));
      if (px[k] > 11'd600) chk("x_range", k, int'(px[k]), 600);
      if (py[k] > 11'd450) chk("y_range", k, int'(py[k]), 450);
      upd_cnt[k] += int'(up[k]);
      bnc_cnt[k] += int'(bx[k]) + int'(by[k]);
    end
  end

  task automatic tick(bit p);
    @(negedge clk);
    frame_tick = 1; pause = p;
    @(negedge clk);
    frame_tick = 0; pause = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  int u_base;
  int b_base;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1;
    #1;
    chk("lit_rst_x", 0, int'(px[0]), 200);
    chk("lit_rst_y", 0, int'(py[0]), 200);
    chk("lit_rst_dx", 0, int'(ddx[0]), 1);

    speed = 4'd1;
    tick(0);
    chk("lit_edge_599", 3, int'(px[3]), 599);
    chk("lit_corner_x", 2, int'(px[2]), 600);
    chk("lit_corner_y", 2, int'(py[2]), 450);
    chk("lit_corner_bx", 2, int'(bx[2]), 1);
    chk("lit_corner_by", 2, int'(by[2]), 1);
    chk("lit_corner_dy", 2, int'(ddy[2]), 0);
    tick(0);
    chk("lit_edge_600", 3, int'(px[3]), 600);
    chk("lit_edge_dx", 3, int'(ddx[3]), 0);
    chk("lit_edge_bx", 3, int'(bx[3]), 1);
    @(negedge clk);
    chk("lit_bx_one", 3, int'(bx[3]), 0);
    tick(0);
    chk("lit_back_599", 3, int'(px[3]), 599);
    chk("lit_t1_x", 0, int'(px[0]), 203);
    chk("lit_t1_y", 0, int'(py[0]), 203);

    do_reset();
    speed = 4'd4;
    u_base = upd_cnt[1];
    repeat (9) tick(0);
    chk("lit_div_x", 1, int'(px[1]), 212);
    chk("lit_div_y", 1, int'(py[1]), 450);
    chk("lit_div_dy", 1, int'(ddy[1]), 0);
    chk("lit_div_upd", 1, upd_cnt[1] - u_base, 3);

    do_reset();
    u_base = upd_cnt[1];
    for (int t = 1; t <= 9; t++) tick(t >= 4 && t <= 6);
    chk("lit_pause_x", 1, int'(px[1]), 208);
    chk("lit_pause_upd", 1, upd_cnt[1] - u_base, 2);

    @(negedge clk);
    frame_tick = 1;
    @(negedge clk);
    frame_tick = 0;
    rst_n = 0;
    #1;
    chk("lit_arst_x", 0, int'(px[0]), 200);
    chk("lit_arst_upd", 0, int'(up[0]), 0);
    @(negedge clk);
    rst_n = 1;
    speed = 4'd0;
    u_base = upd_cnt[0];
    b_base = bnc_cnt[0];
    repeat (10) tick(0);
    chk("lit_s0_x", 0, int'(px[0]), 200);
    chk("lit_s0_upd", 0, upd_cnt[0] - u_base, 10);
    chk("lit_s0_bnc", 0, bnc_cnt[0] - b_base, 0);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(499) == 0) rst_n = 0;
      else rst_n = 1;
      frame_tick = ($urandom_range(2) == 0);
      pause = ($urandom_range(7) == 0);
      speed = 4'($urandom_range(15));
    end
    @(negedge clk);
    rst_n = 1; frame_tick = 0; pause = 0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
